// File: rtl/poly_note_player.sv
// Polyphonic square-wave note player: timed note requests are assigned to
// CHANNELS voices whose outputs are mixed into a single PWM bit.
module poly_note_player #(
    parameter int CHANNELS    = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DUR_WIDTH   = 12,
    parameter int TICK_CYCLES = 50000,
    parameter int STEAL       = 0,
    localparam int LW = $clog2(CHANNELS + 1)
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic                 iNoteValid,
    output logic                 oNoteReady,
    input  logic [DIV_WIDTH-1:0] iHalfPeriod,
    input  logic [DUR_WIDTH-1:0] iDuration,
    input  logic                 iRelease,
    output logic [CHANNELS-1:0]  oActive,
    output logic [LW-1:0]        oLevel,
    output logic                 oPWM
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int MW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [PW-1:0]        presc_q, presc_d;
    logic [MW-1:0]        mix_q, mix_d;
    logic [MW-1:0]        ptr_q, ptr_d;
    logic [CHANNELS-1:0]  busy_q, busy_d;
    logic [CHANNELS-1:0]  sq_q, sq_d;
    logic [DIV_WIDTH-1:0] phase_q [CHANNELS];
    logic [DIV_WIDTH-1:0] phase_d [CHANNELS];
    logic [DIV_WIDTH-1:0] half_q  [CHANNELS];
    logic [DIV_WIDTH-1:0] half_d  [CHANNELS];
    logic [DUR_WIDTH-1:0] rem_q   [CHANNELS];
    logic [DUR_WIDTH-1:0] rem_d   [CHANNELS];
    logic [LW-1:0]        level_q, level_d;
    logic                 pwm_q, pwm_d;

    logic          tick;
    logic          found;
    logic [MW-1:0] sel;
    logic          load_en;

    assign tick = (presc_q == PW'(TICK_CYCLES - 1));

    // Lowest idle voice wins; with none idle the steal pointer is used.
    always_comb begin
        found = 1'b0;
        sel   = ptr_q;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
                found = 1'b1;
                sel   = MW'(k);
            end
        end
    end

    assign oNoteReady = !iReset && !iRelease && ((STEAL != 0) || found);
    assign load_en    = iNoteValid && oNoteReady && (iDuration != '0);

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        mix_d   = (mix_q == MW'(CHANNELS - 1)) ? '0 : mix_q + MW'(1);
        ptr_d   = ptr_q;
        if (load_en && !found) begin
            ptr_d = (ptr_q == MW'(CHANNELS - 1)) ? '0 : ptr_q + MW'(1);
        end
    end

    always_comb begin
        busy_d = busy_q;
        sq_d   = sq_q;
        for (int k = 0; k < CHANNELS; k++) begin
            phase_d[k] = phase_q[k];
            half_d[k]  = half_q[k];
            rem_d[k]   = rem_q[k];
            if (busy_q[k]) begin
                if (half_q[k] != '0) begin
                    if (phase_q[k] == half_q[k] - DIV_WIDTH'(1)) begin
                        phase_d[k] = '0;
                        sq_d[k]    = ~sq_q[k];
                    end else begin
                        phase_d[k] = phase_q[k] + DIV_WIDTH'(1);
                    end
                end
                if (tick) begin
                    if (rem_q[k] == DUR_WIDTH'(1)) begin
                        busy_d[k] = 1'b0;
                        sq_d[k]   = 1'b0;
                    end else begin
                        rem_d[k] = rem_q[k] - DUR_WIDTH'(1);
                    end
                end
            end
            // A fresh load overrides this edge's tick decrement.
            if (load_en && sel == MW'(k)) begin
                busy_d[k]  = 1'b1;
                sq_d[k]    = 1'b0;
                phase_d[k] = '0;
                half_d[k]  = iHalfPeriod;
                rem_d[k]   = iDuration;
            end
            if (iRelease) begin
                busy_d[k]  = 1'b0;
                sq_d[k]    = 1'b0;
                phase_d[k] = '0;
            end
        end
    end

    always_comb begin
        level_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            level_d = level_d + LW'(sq_q[k] & busy_q[k]);
        end
        pwm_d = (LW'(mix_q) < level_q);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            presc_q <= '0;
            mix_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= '0;
            sq_q    <= '0;
            level_q <= '0;
            pwm_q   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                phase_q[k] <= '0;
                half_q[k]  <= '0;
                rem_q[k]   <= '0;
            end
        end else begin
            presc_q <= presc_d;
            mix_q   <= mix_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            sq_q    <= sq_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
            for (int k = 0; k < CHANNELS; k++) begin
                phase_q[k] <= phase_d[k];
                half_q[k]  <= half_d[k];
                rem_q[k]   <= rem_d[k];
            end
        end
    end

    assign oActive = busy_q;
    assign oLevel  = level_q;
    assign oPWM    = pwm_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: a backpressure and a stealing instance share
// stimulus and are compared every cycle against a timeline-based voice model.
module tb_poly_note_player;

    localparam int CH = 4;
    localparam int TC = 10;

    logic        clk = 1'b0;
    logic        rst, valid, rel;
    logic [15:0] half;
    logic [11:0] dur;
    logic        rdy0, rdy1, pwm0, pwm1;
    logic [3:0]  act0, act1;
    logic [2:0]  lvl0, lvl1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_note_player #(.CHANNELS(CH), .DIV_WIDTH(16), .DUR_WIDTH(12),
                       .TICK_CYCLES(TC), .STEAL(0)) u0 (
        .iClk(clk), .iReset(rst), .iNoteValid(valid), .oNoteReady(rdy0),
        .iHalfPeriod(half), .iDuration(dur), .iRelease(rel),
        .oActive(act0), .oLevel(lvl0), .oPWM(pwm0));

    poly_note_player #(.CHANNELS(CH), .DIV_WIDTH(16), .DUR_WIDTH(12),
                       .TICK_CYCLES(TC), .STEAL(1)) u1 (
        .iClk(clk), .iReset(rst), .iNoteValid(valid), .oNoteReady(rdy1),
        .iHalfPeriod(half), .iDuration(dur), .iRelease(rel),
        .oActive(act1), .oLevel(lvl1), .oPWM(pwm1));

    // Each voice is a record: load edge, half period, edge at which it frees.
    int e = 0;
    int r = 0;
    int ld [2][CH];
    int hp [2][CH];
    int en [2][CH];
    int ptr [2];
    int mlvl [2];
    bit mpwm [2];
    bit exp_rdy [2];
    bit obs_rdy [2];

    function automatic bit mbusy(int s, int k, int t);
        return ld[s][k] <= t && t < en[s][k];
    endfunction

    function automatic bit msq(int s, int k, int t);
        if (!mbusy(s, k, t) || hp[s][k] == 0) return 1'b0;
        return ((t - ld[s][k]) / hp[s][k]) % 2 == 1;
    endfunction

    function automatic void model_edge();
        int t = e + 1;
        for (int s = 0; s < 2; s++) begin
            bit idle[CH];
            bit any_idle = 0;
            int lv = 0;
            bit rd, np;
            int pick = -1;
            for (int k = 0; k < CH; k++) begin
                idle[k] = !mbusy(s, k, e);
                if (idle[k]) any_idle = 1;
                if (msq(s, k, e)) lv++;
            end
            rd = !rst && !rel && (s == 1 || any_idle);
            exp_rdy[s] = rd;
            np = ((e - r) % CH) < mlvl[s];
            if (rst) begin
                for (int k = 0; k < CH; k++) if (en[s][k] > t) en[s][k] = t;
                ptr[s] = 0;
                mlvl[s] = 0;
                mpwm[s] = 0;
            end else begin
                mlvl[s] = lv;
                mpwm[s] = np;
                if (rel) begin
                    for (int k = 0; k < CH; k++) if (en[s][k] > t) en[s][k] = t;
                end else if (valid && rd && dur != 0) begin
                    for (int k = CH - 1; k >= 0; k--) if (idle[k]) pick = k;
                    if (pick < 0) begin
                        pick = ptr[s];
                        ptr[s] = (ptr[s] + 1) % CH;
                    end
                    ld[s][pick] = t;
                    hp[s][pick] = int'(half);
                    en[s][pick] = r + ((t - r) / TC + int'(dur)) * TC;
                end
            end
        end
        if (rst) r = t;
        e = t;
    endfunction

    function automatic logic [8:0] exp_vec(int s);
        logic [3:0] a;
        for (int k = 0; k < CH; k++) a[k] = mbusy(s, k, e);
        return {exp_rdy[s], a, 3'(mlvl[s]), mpwm[s]};
    endfunction

    function automatic logic [8:0] obs_vec(int s);
        if (s == 0) return {obs_rdy[0], act0, lvl0, pwm0};
        return {obs_rdy[1], act1, lvl1, pwm1};
    endfunction

    task automatic drive(bit v, int h, int d, bit rl, bit rs);
        valid = v;
        half  = 16'(h);
        dur   = 12'(d);
        rel   = rl;
        rst   = rs;
    endtask

    task automatic step();
        @(negedge clk);
        obs_rdy[0] = rdy0;
        obs_rdy[1] = rdy1;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < CH; k++)
            for (int s = 0; s < 2; s++) begin
                ld[s][k] = 0;
                en[s][k] = 0;
                hp[s][k] = 0;
            end
        drive(0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== 9'b0) begin
                    errors++;
                    $display("FAIL reset dut%0d: got %b need %b", s, obs_vec(s), 9'b0);
                end
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_single_note();
        drive(1, 3, 2, 0, 0);
        step();
        checks++;
        if (act0 !== 4'b0001) begin
            errors++;
            $display("FAIL single_active: got %b need %b", act0, 4'b0001);
        end
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 30; c++) begin
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL single dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 75; c++) begin
            if (c < 5) drive(1, $urandom_range(1, 5), 5, 0, 0);
            else if (c < 70) drive(1, 2, 3, 0, 0);
            else drive(0, 0, 0, 0, 0);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL backpressure dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_steal();
        for (int c = 0; c < 40; c++) begin
            if (c < 6) drive(1, 2 + c, 8, 0, 0);
            else drive(0, 0, 0, 0, 0);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL steal dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    task automatic test_release();
        drive(0, 0, 0, 1, 0);
        step();
        for (int c = 0; c < 12; c++) begin
            if (c < 3) drive(1, 4, 6, 0, 0);
            else if (c == 3) drive(1, 5, 6, 1, 0);
            else if (c == 4) drive(1, 5, 6, 0, 0);
            else drive(0, 0, 0, 0, 0);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL release dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    task automatic test_rest_pwm();
        drive(0, 0, 0, 1, 0);
        step();
        for (int c = 0; c < 100; c++) begin
            if (c < 2) drive(1, 40, 9, 0, 0);
            else if (c == 2) drive(1, 0, 9, 0, 0);
            else drive(0, 0, 0, 0, 0);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL rest_pwm dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 22; c++) begin
            if (c < 3) drive(1, 3, 4, 0, 0);
            else if (c == 7) drive(1, 3, 4, 0, 1);
            else if (c == 8) drive(1, 2, 1, 0, 0);
            else drive(0, 0, 0, 0, 0);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d edge %0d: got %b need %b",
                             s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 4),
                  $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
            step();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (obs_vec(s) !== exp_vec(s)) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL random dut%0d edge %0d: got %b need %b",
                                 s, e, obs_vec(s), exp_vec(s));
                end
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        test_reset();
        test_single_note();
        test_backpressure();
        test_steal();
        test_release();
        test_rest_pwm();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
